operand_feeder: RTL and testbench
=================================

# operand_feeder

Upstream stage of the BRAM/DSP multiplier top level. It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It replays the pairs one per clock onto the multiplier's `dataA`/`dataB` inputs. After the last pair of each frame it inserts the all-ones start sentinel (`{dataA,dataB}` = 8'hFF), which is what launches the multiplier controller.

## Interface
Parameters:
- `DATA_WIDTH`, 4: operand width; must match the multiplier top level.
- `FIFO_DEPTH`, 8: buffered pairs, power of two, at least 2.
- `CNT_WIDTH`, 8: width of `frame_cnt` and `drop_cnt`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream pair valid.
- `in_ready`  out  1  feeder can accept a pair.
- `in_a`  in  DATA_WIDTH  operand A.
- `in_b`  in  DATA_WIDTH  operand B.
- `in_last`  in  1  marks the final pair of a frame.
- `dataA`  out  DATA_WIDTH  registered; to multiplier `dataA`.
- `dataB`  out  DATA_WIDTH  registered; to multiplier `dataB`.
- `busy`  out  1  FIFO non-empty or state not IDLE.
- `frame_cnt`  out  CNT_WIDTH  sentinels emitted; wraps.
- `drop_cnt`  out  CNT_WIDTH  pairs dropped by the filter; saturates.

## Operation
- **Push:**
  - A pair is accepted on a rising edge with `in_valid && in_ready`.
  - `in_ready = !fifo_full`; no full bypass, so a simultaneous pop does not free space that cycle.
  - Each FIFO entry is {a, b, last, marker}.
- **States:**
  - IDLE
    - Outputs hold 0.
    - FIFO non-empty → SEND (pop).
  - SEND
    - Drives the popped pair for exactly one cycle.
    - Non-marker with last=0: pop the next entry if available and stay in SEND, otherwise → IDLE.
    - last=1 → SENT. No pop this cycle.
    - A marker entry drives 0 in place of its pair and goes straight to SENT.
  - SENT
    - Drives 8'hFF for exactly one cycle.
    - `frame_cnt` increments, wrapping from 2^CNT_WIDTH−1 to 0.
    - Then → SEND if the FIFO is non-empty, else → IDLE.
- **Idle pattern:** `dataA` = `dataB` = 0 whenever the block is not driving a pair or a sentinel.
- **No sentinel without last:** a frame with no `in_last` streams without a sentinel. It continues into the next frame unchanged.
- **Reset:** asserting `rst_n` low at any time, including mid-frame:
  - flushes the FIFO;
  - sets the state to IDLE;
  - zeroes `dataA`, `dataB` and both counters;
  - holds `in_ready` = 0 and `busy` = 0.
- **After reset:** `in_ready` = 1 on the first cycle after reset deasserts.

## Timing
- **Latency:** with the FIFO empty and the block in IDLE, a pair accepted at edge N appears on `dataA`/`dataB` after edge N+1.
  - The pop occurs at edge N+1 and the output register loads at that same edge.
- **Throughput:** back-to-back pairs in the FIFO go out one per cycle with no gaps. The only exception is the single sentinel cycle after each last pair.
- **Sentinel position:** the sentinel always appears in the cycle directly after the last pair's cycle.
- **`busy`:** goes high the cycle after the first push. It falls in the cycle the block returns to IDLE with the FIFO empty.

## Configuration
Macro: `OPERAND_FEEDER_SENTINEL_FILTER_EN`.
- **Defined:**
  - An input pair equal to the sentinel (all ones in both operands) is not enqueued as data.
  - `drop_cnt` increments and saturates at all ones.
  - If that pair had `in_last` = 1, a marker entry is enqueued so the frame still ends with exactly one sentinel.
  - A marker consumes one FIFO slot; `in_ready` rules are unchanged.
- **Not defined:**
  - Sentinel-valued pairs pass through as data and will start the multiplier early.
  - `drop_cnt` is tied to 0.

## Structure
- **Shared package `operand_feeder_pkg`:**
  - state enum (IDLE, SEND, SENT);
  - FIFO entry struct;
  - `SENTINEL` constant (all ones for 2*DATA_WIDTH);
  - idle-pattern constant (0).
- **Sub-module `sync_fifo`:** parameterised width and depth, registered full/empty flags, pointers one bit wider than the address. The top-level FSM, output registers and counters stay in `operand_feeder`.

## Test plan
- **Single pair:** push (3,5) with `in_last`=1 into an idle block → (3,5) after edge N+1, then 8'hFF for one cycle, then 0. `frame_cnt`=1.
- **Back-to-back and full:** push 8 pairs with no pops possible → `in_ready`=0 after the 8th push. The pairs drain one per cycle in order, then the sentinel. `in_ready` returns to 1 the cycle after the first pop.
- **Filter, last pair:** with the macro defined, push (2,2), (F,F, last=1) → output (2,2), 0, then FF. `drop_cnt`=1, `frame_cnt`=1.
- **Filter off:** without the macro, the same stimulus → (2,2), FF, FF. `drop_cnt`=0.
- **Reset mid-frame:** reset during SEND with 4 pairs queued → outputs 0, `busy`=0, `in_ready`=0 while reset is held. No residual pairs appear afterwards.
- **Counter wrap:** 256 single-pair frames with `CNT_WIDTH`=8 → `frame_cnt` wraps to 0.

Source files
------------

// File: rtl/operand_feeder_pkg.sv
// Shared types and constants for the operand feeder: FSM states, FIFO entry layout,
// and the start sentinel / idle patterns presented to the multiplier.
package operand_feeder_pkg;

   localparam int unsigned OPND_W = 4;
   localparam int unsigned WORD_W = 2 * OPND_W;

   localparam logic [WORD_W-1:0] SENTINEL = '1;
   localparam logic [WORD_W-1:0] IDLE_PAT = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      SENT = 2'd2
   } state_t;

   // marker: stands in for a filtered sentinel pair that carried in_last
   typedef struct packed {
      logic [OPND_W-1:0] a;
      logic [OPND_W-1:0] b;
      logic              last;
      logic              marker;
   } fifo_entry_t;

   function automatic logic is_sentinel(input logic [WORD_W-1:0] w);
      return w == SENTINEL;
   endfunction

endpackage

// File: rtl/operand_feeder_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and extra-MSB wrap pointers.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
   logic             do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign wr_d    = wr_q + (AW+1)'(do_push);
   assign rd_d    = rd_q + (AW+1)'(do_pop);

   // Flags come from the next pointers so they are valid right after each edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         full  <= (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
         empty <= (wr_d == rd_d);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_q[AW-1:0]] <= wdata;
      end
   end

   assign rdata = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/operand_feeder.sv
// Buffers operand pairs and replays them to the multiplier, appending the all-ones
// start sentinel after each frame. Optional sentinel filter: OPERAND_FEEDER_SENTINEL_FILTER_EN.
module operand_feeder
   import operand_feeder_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = OPND_W,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic                  in_last,
   output logic [DATA_WIDTH-1:0] dataA,
   output logic [DATA_WIDTH-1:0] dataB,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   output logic [CNT_WIDTH-1:0]  drop_cnt
);

   localparam int unsigned ENT_W = $bits(fifo_entry_t);

   fifo_entry_t           wr_ent, rd_ent;
   logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic                  live_q, accept;
   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic                  last_q, last_d, load_next, frame_inc;
   logic [CNT_WIDTH-1:0]  frame_q, drop_q;

   // Keeps in_ready low while reset is held, high from the first edge after release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) live_q <= 1'b0;
      else        live_q <= 1'b1;
   end

   assign in_ready = live_q && !fifo_full;
   assign accept   = in_valid && in_ready;

   always_comb begin
      wr_ent    = '{a: OPND_W'(in_a), b: OPND_W'(in_b), last: in_last, marker: 1'b0};
      fifo_push = accept;
`ifdef OPERAND_FEEDER_SENTINEL_FILTER_EN
      // Sentinel-valued data is dropped; a last pair leaves a zero-valued marker behind
      if (is_sentinel({wr_ent.a, wr_ent.b})) begin
         wr_ent.a      = '0;
         wr_ent.b      = '0;
         wr_ent.marker = 1'b1;
         fifo_push     = accept && in_last;
      end
`endif
   end

   sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata (wr_ent),
      .pop   (fifo_pop),
      .rdata (rd_ent),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         last_q  <= 1'b0;
         frame_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         last_q  <= last_d;
         if (frame_inc) frame_q <= frame_q + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      {a_d, b_d} = (2*DATA_WIDTH)'(IDLE_PAT);
      last_d     = last_q;
      fifo_pop   = 1'b0;
      frame_inc  = 1'b0;
      load_next  = 1'b0;

      case (state_q)
         IDLE: load_next = 1'b1;
         SEND: begin
            if (last_q) begin
               state_d    = SENT;
               {a_d, b_d} = (2*DATA_WIDTH)'(SENTINEL);
               frame_inc  = 1'b1;
            end else begin
               load_next = 1'b1;
            end
         end
         SENT: load_next = 1'b1;
         default: state_d = IDLE;
      endcase

      // Markers hold zero operands, so they drive the idle pattern for their cycle
      if (load_next) begin
         if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = SEND;
            a_d      = DATA_WIDTH'(rd_ent.a);
            b_d      = DATA_WIDTH'(rd_ent.b);
            last_d   = rd_ent.last || rd_ent.marker;
         end else begin
            state_d = IDLE;
         end
      end
   end

`ifdef OPERAND_FEEDER_SENTINEL_FILTER_EN
   logic sent_hit;
   assign sent_hit = accept && is_sentinel({OPND_W'(in_a), OPND_W'(in_b)});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    drop_q <= '0;
      else if (sent_hit && !(&drop_q)) drop_q <= drop_q + CNT_WIDTH'(1);
   end
`else
   assign drop_q = '0;
`endif

   assign dataA     = a_q;
   assign dataB     = b_q;
   assign busy      = !fifo_empty || (state_q != IDLE);
   assign frame_cnt = frame_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_operand_feeder.sv
// Self-checking bench for operand_feeder: directed timing cases plus randomized frames
// checked against an ordered queue of expected words built from accepted pairs.
module tb_operand_feeder;

   localparam int unsigned DW = 4;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_a = '0;
   logic [DW-1:0] in_b = '0;
   logic          in_last = 1'b0;
   logic [DW-1:0] dataA, dataB;
   logic          busy;
   logic [CW-1:0] frame_cnt, drop_cnt;

   operand_feeder #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (8),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .dataA     (dataA),
      .dataB     (dataB),
      .busy      (busy),
      .frame_cnt (frame_cnt),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   int            total = 0;
   int            bad = 0;
   logic [7:0]    expq[$];
   logic [7:0]    olog[$];
   logic [CW-1:0] frame_exp = '0;
   logic [CW-1:0] drop_exp = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Every non-idle output word must be the next expected pair or sentinel, in order
   always begin
      logic [7:0] w;
      @(posedge clk);
      #1;
      w = {dataA, dataB};
      olog.push_back(w);
      if (rst_n && w != 8'h00) begin
         if (expq.size() == 0) chk("unexpected_out", 32'(w), 32'h0);
         else                  chk("stream", 32'(w), 32'(expq.pop_front()));
      end
   end

   task automatic model_push(input logic [3:0] a, input logic [3:0] b, input logic last);
`ifdef OPERAND_FEEDER_SENTINEL_FILTER_EN
      if (a == 4'hF && b == 4'hF) begin
         if (drop_exp != '1) drop_exp++;
         if (last) begin
            expq.push_back(8'hFF);
            frame_exp++;
         end
         return;
      end
`endif
      expq.push_back({a, b});
      if (last) begin
         expq.push_back(8'hFF);
         frame_exp++;
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic push(input logic [3:0] a, input logic [3:0] b, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_last = last;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("push_timeout", 32'(in_ready), 32'h1);
      else           model_push(a, b, last);
      @(negedge clk);
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || expq.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_busy", 32'(busy), 32'h0);
      chk("drain_left", 32'(expq.size()), 32'h0);
      repeat (2) @(negedge clk);
      chk("frame_cnt", 32'(frame_cnt), 32'(frame_exp));
      chk("drop_cnt", 32'(drop_cnt), 32'(drop_exp));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      expq.delete();
      frame_exp = '0;
      drop_exp = '0;
      #1;
      chk("rst_data", 32'({dataA, dataB}), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ready", 32'(in_ready), 32'h0);
      chk("rst_frame", 32'(frame_cnt), 32'h0);
      chk("rst_drop", 32'(drop_cnt), 32'h0);
      @(negedge clk);
      in_valid = 1'b1;
      in_a = 4'h6;
      in_b = 4'h7;
      @(negedge clk);
      in_valid = 1'b0;
      chk("rst_ready_hold", 32'(in_ready), 32'h0);
      chk("rst_busy_hold", 32'(busy), 32'h0);
      chk("rst_data_hold", 32'({dataA, dataB}), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(in_ready), 32'h1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int n;
      bit saw;
      logic [3:0] ra, rb;
      logic rl;

      #1;
      do_reset();

      // Single pair: visible one edge after acceptance, then sentinel, then idle
      idx = olog.size();
      push(4'h3, 4'h5, 1'b1);
      chk("busy_after_push", 32'(busy), 32'h1);
      drain();
      chk("single_pre", 32'(olog[idx]), 32'h00);
      chk("single_pair", 32'(olog[idx+1]), 32'h35);
      chk("single_sent", 32'(olog[idx+2]), 32'hFF);
      chk("single_idle", 32'(olog[idx+3]), 32'h00);

      // Back-to-back frame of 8: gapless output, sentinel directly after the last pair
      idx = olog.size();
      for (int i = 0; i < 8; i++) push(4'(i + 1), 4'(i + 2), (i == 7));
      drain();
      for (int i = 0; i < 8; i++)
         chk("burst_pair", 32'(olog[idx+1+i]), 32'({4'(i + 1), 4'(i + 2)}));
      chk("burst_sent", 32'(olog[idx+9]), 32'hFF);
      chk("burst_idle", 32'(olog[idx+10]), 32'h00);

      // Sentinel-valued pair as the last of a frame
      idx = olog.size();
      push(4'h2, 4'h2, 1'b0);
      push(4'hF, 4'hF, 1'b1);
      drain();
      chk("filt_pair", 32'(olog[idx+1]), 32'h22);
`ifdef OPERAND_FEEDER_SENTINEL_FILTER_EN
      chk("filt_marker", 32'(olog[idx+2]), 32'h00);
`else
      chk("filt_data", 32'(olog[idx+2]), 32'hFF);
`endif
      chk("filt_sent", 32'(olog[idx+3]), 32'hFF);
      chk("filt_idle", 32'(olog[idx+4]), 32'h00);

      // Fill with one-pair frames (two output cycles each) until in_ready drops
      saw = 1'b0;
      n = 0;
      while (n < 40 && !saw) begin
         if (!in_ready) saw = 1'b1;
         else begin
            ra = 4'($urandom_range(1, 14));
            rb = 4'($urandom_range(1, 14));
            in_valid = 1'b1;
            in_a = ra;
            in_b = rb;
            in_last = 1'b1;
            model_push(ra, rb, 1'b1);
            @(negedge clk);
            n++;
         end
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      chk("full_reached", 32'(saw), 32'h1);
      chk("full_on_sentinel", 32'({dataA, dataB}), 32'hFF);
      @(negedge clk);
      chk("ready_after_pop", 32'(in_ready), 32'h1);
      chk("pop_shows_pair", 32'({dataA, dataB} != 8'h00 && {dataA, dataB} != 8'hFF), 32'h1);
      drain();

      // Random frames with idle gaps; occasional sentinel-valued pairs
      for (int i = 0; i < 300; i++) begin
         ra = 4'($urandom_range(1, 15));
         rb = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) begin
            ra = 4'hF;
            rb = 4'hF;
         end
         rl = ($urandom_range(0, 3) == 0);
         push(ra, rb, rl);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      drain();

      // Reset mid-frame: nothing queued before reset may appear afterwards
      for (int i = 0; i < 8; i++) push(4'(i + 3), 4'h1, 1'b0);
      do_reset();
      idx = olog.size();
      repeat (14) @(negedge clk);
      for (int i = 0; i < 12; i++) chk("no_residual", 32'(olog[idx+i]), 32'h00);
      chk("post_rst_busy", 32'(busy), 32'h0);

      // 256 one-pair frames wrap frame_cnt back to zero
      for (int i = 0; i < 256; i++) push(4'($urandom_range(1, 14)), 4'($urandom_range(0, 14)), 1'b1);
      drain();
      chk("frame_wrap", 32'(frame_cnt), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
